stage3_execute: RTL and testbench



---
 rtl/pipe_pkg.sv | 20 ++
 rtl/stage3_execute_if.sv | 31 +++
 rtl/alu32.sv | 24 ++
 rtl/stage3_execute.sv | 60 ++++++
 tb/tb_stage3_execute.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath/register-index widths and ALU op encodings,
// common to decode, control and execute.
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 16;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_SLL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  function automatic logic [DATA_W-1:0] sign_ext16(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction
endpackage

// File: rtl/stage3_execute_if.sv
// Execute-stage bus: decoded inputs and stall/flush in, EX/WB register contents out.
interface stage3_execute_if #(parameter int CNT_W = 16);
  import pipe_pkg::*;

  logic [DATA_W-1:0] RD1_IN;
  logic [DATA_W-1:0] RD2_IN;
  logic [IMM_W-1:0]  IMM_IN;
  logic              DataSource_IN;
  logic [2:0]        ALUOp_IN;
  logic [REG_W-1:0]  WriteSelect_IN;
  logic              WriteEnable_IN;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] ALUResult_OUT;
  logic [REG_W-1:0]  WriteSelect_OUT;
  logic              WriteEnable_OUT;
  logic              Zero_OUT;
  logic [CNT_W-1:0]  WriteCount_OUT;

  modport master (
    output RD1_IN, RD2_IN, IMM_IN, DataSource_IN, ALUOp_IN,
           WriteSelect_IN, WriteEnable_IN, stall, flush,
    input  ALUResult_OUT, WriteSelect_OUT, WriteEnable_OUT, Zero_OUT, WriteCount_OUT
  );

  modport slave (
    input  RD1_IN, RD2_IN, IMM_IN, DataSource_IN, ALUOp_IN,
           WriteSelect_IN, WriteEnable_IN, stall, flush,
    output ALUResult_OUT, WriteSelect_OUT, WriteEnable_OUT, Zero_OUT, WriteCount_OUT
  );
endinterface

// File: rtl/alu32.sv
// Combinational 32-bit ALU; results wrap modulo 2^32, overflow is ignored.
module alu32
  import pipe_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result
);
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL:   result = a << b[4:0];
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end
endmodule

// File: rtl/stage3_execute.sv
// Execute stage: operand-B select, ALU, and the EX/WB register with stall/flush
// plus a counter of captured write-backs.
module stage3_execute
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  stage3_execute_if.slave  bus
);
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_result;

  logic [DATA_W-1:0] r_result;
  logic [REG_W-1:0]  r_ws;
  logic              r_we;
  logic              r_zero;
  logic [CNT_W-1:0]  r_cnt;

  assign w_b = bus.DataSource_IN ? sign_ext16(bus.IMM_IN) : bus.RD2_IN;

  alu32 u_alu (
    .a      (bus.RD1_IN),
    .b      (w_b),
    .op     (bus.ALUOp_IN),
    .result (w_result)
  );

  // Priority: reset > flush > stall > load. The zero flag is computed from the
  // same value being captured so flag and result always belong to one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_ws     <= '0;
      r_we     <= 1'b0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
    end else if (bus.flush) begin
      r_result <= '0;
      r_ws     <= '0;
      r_we     <= 1'b0;
      r_zero   <= 1'b0;
    end else if (!bus.stall) begin
      r_result <= w_result;
      r_ws     <= bus.WriteSelect_IN;
      r_we     <= bus.WriteEnable_IN;
      r_zero   <= (w_result == '0);
      if (bus.WriteEnable_IN) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.ALUResult_OUT   = r_result;
  assign bus.WriteSelect_OUT = r_ws;
  assign bus.WriteEnable_OUT = r_we;
  assign bus.Zero_OUT        = r_zero;
  assign bus.WriteCount_OUT  = r_cnt;
endmodule

// File: tb/tb_stage3_execute.sv
// Directed bench for stage3_execute: vector table for ALU/B-mux, then hand
// sequences for stall, flush, counter wrap and mid-stream reset.
module tb_stage3_execute;
  import pipe_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [15:0] cnt_exp;

  stage3_execute_if #(.CNT_W(16)) bus ();

  stage3_execute #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] rd2;
    logic [15:0] imm;
    logic        src;
    logic [4:0]  ws;
    logic        we;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd2,
                       input logic [15:0] imm, input logic src, input logic [4:0] ws,
                       input logic we);
    bus.ALUOp_IN       = op;
    bus.RD1_IN         = a;
    bus.RD2_IN         = rd2;
    bus.IMM_IN         = imm;
    bus.DataSource_IN  = src;
    bus.WriteSelect_IN = ws;
    bus.WriteEnable_IN = we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] res, input logic [4:0] ws,
                         input logic we, input logic z);
    chk({tag, ".result"}, bus.ALUResult_OUT, res);
    chk({tag, ".ws"},     {27'd0, bus.WriteSelect_OUT}, {27'd0, ws});
    chk({tag, ".we"},     {31'd0, bus.WriteEnable_OUT}, {31'd0, we});
    chk({tag, ".zero"},   {31'd0, bus.Zero_OUT}, {31'd0, z});
    chk({tag, ".count"},  {16'd0, bus.WriteCount_OUT}, {16'd0, cnt_exp});
    $display("txn %s: res=0x%08h ws=%0d we=%0d z=%0d cnt=%0d", tag, bus.ALUResult_OUT,
             bus.WriteSelect_OUT, bus.WriteEnable_OUT, bus.Zero_OUT, bus.WriteCount_OUT);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    cnt_exp = '0;

    vecs[0]  = '{ALU_ADD,   32'h5,        32'h7,        16'h0,    1'b0, 5'd3, 1'b1, 32'h0000000C, 1'b0};
    vecs[1]  = '{ALU_SUB,   32'h10,       32'hDEAD,     16'hFFF0, 1'b1, 5'd4, 1'b1, 32'h00000020, 1'b0};
    vecs[2]  = '{ALU_SUB,   32'h1234,     32'h1234,     16'h0,    1'b0, 5'd5, 1'b1, 32'h00000000, 1'b1};
    vecs[3]  = '{ALU_SLT,   32'hFFFFFFFF, 32'h1,        16'h0,    1'b0, 5'd6, 1'b1, 32'h00000001, 1'b0};
    vecs[4]  = '{ALU_SLL,   32'h1,        32'h25,       16'h0,    1'b0, 5'd7, 1'b1, 32'h00000020, 1'b0};
    vecs[5]  = '{ALU_PASSB, 32'h12345678, 32'h0,        16'h8000, 1'b1, 5'd8, 1'b1, 32'hFFFF8000, 1'b0};
    vecs[6]  = '{ALU_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 16'h0,    1'b0, 5'd9, 1'b0, 32'h00F000F0, 1'b0};
    vecs[7]  = '{ALU_OR,    32'h00000F00, 32'h000000F0, 16'h0,    1'b0, 5'd10, 1'b1, 32'h00000FF0, 1'b0};
    vecs[8]  = '{ALU_XOR,   32'hFFFF0000, 32'hFF00FF00, 16'h0,    1'b0, 5'd11, 1'b1, 32'h00FFFF00, 1'b0};
    vecs[9]  = '{ALU_ADD,   32'hFFFFFFFF, 32'h1,        16'h0,    1'b0, 5'd0, 1'b1, 32'h00000000, 1'b1};
    vecs[10] = '{ALU_SLT,   32'h1,        32'hFFFFFFFF, 16'h0,    1'b0, 5'd12, 1'b0, 32'h00000000, 1'b1};
    vecs[11] = '{ALU_SLL,   32'h80000001, 32'h1F,       16'h0,    1'b0, 5'd13, 1'b1, 32'h80000000, 1'b0};

    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(ALU_ADD, 32'h1, 32'h1, 16'h0, 1'b0, 5'd1, 1'b1);
    tick();
    tick();
    chk_all("reset", 32'h0, 5'd0, 1'b0, 1'b0);

    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].rd2, vecs[i].imm, vecs[i].src, vecs[i].ws, vecs[i].we);
      tick();
      if (vecs[i].we) cnt_exp++;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].ws, vecs[i].we, vecs[i].exp_zero);
    end

    // Stall for three cycles with a changing input bus: everything holds.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ALU_ADD, 32'(i + 1), 32'(i + 1), 16'h0, 1'b0, 5'(20 + i), 1'b1);
      tick();
      chk_all($sformatf("stall%0d", i), 32'h80000000, 5'd13, 1'b1, 1'b0);
    end
    bus.stall = 1'b0;
    drive(ALU_ADD, 32'd100, 32'd23, 16'h0, 1'b0, 5'd14, 1'b1);
    tick();
    cnt_exp++;
    chk_all("release", 32'd123, 5'd14, 1'b1, 1'b0);

    // Flush wins over stall: bubble loads, counter holds.
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    drive(ALU_ADD, 32'd9, 32'd9, 16'h0, 1'b0, 5'd15, 1'b1);
    tick();
    chk_all("flush_stall", 32'h0, 5'd0, 1'b0, 1'b0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // Drive the counter up to all-ones, then wrap it.
    drive(ALU_ADD, 32'd0, 32'd0, 16'h0, 1'b0, 5'd1, 1'b1);
    while (cnt_exp != 16'hFFFF) begin
      tick();
      cnt_exp++;
    end
    chk_all("cnt_max", 32'h0, 5'd1, 1'b1, 1'b1);
    tick();
    cnt_exp++;
    chk_all("cnt_wrap", 32'h0, 5'd1, 1'b1, 1'b1);
    drive(ALU_OR, 32'h5, 32'h0, 16'h0, 1'b0, 5'd2, 1'b0);
    tick();
    chk_all("cnt_we0", 32'h5, 5'd2, 1'b0, 1'b0);

    // Reset while stalled with nonzero outputs clears everything.
    drive(ALU_ADD, 32'd3, 32'd4, 16'h0, 1'b0, 5'd2, 1'b1);
    tick();
    cnt_exp++;
    chk_all("pre_reset", 32'd7, 5'd2, 1'b1, 1'b0);
    bus.stall = 1'b1;
    reset     = 1'b1;
    tick();
    cnt_exp = '0;
    chk_all("reset_stall", 32'h0, 5'd0, 1'b0, 1'b0);
    reset     = 1'b0;
    bus.stall = 1'b0;
    drive(ALU_ADD, 32'd1, 32'd2, 16'h0, 1'b0, 5'd6, 1'b1);
    tick();
    cnt_exp++;
    chk_all("post_reset", 32'd3, 5'd6, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
